// File: rtl/alu_control_unit_if.sv
// Decode-request / decoded-result bundle between the control path and alu_control_unit.
// With ALUCTL_ERR_COUNT_EN defined, the bundle also carries the illegal-decode counter.
interface alu_control_unit_if;
    logic       en;
    logic [1:0] ALUOp;
    logic [5:0] funct;
    logic [3:0] alu_control;
    logic       illegal;
`ifdef ALUCTL_ERR_COUNT_EN
    logic [7:0] err_count;

    modport master (output en, ALUOp, funct, input alu_control, illegal, err_count);
    modport slave  (input en, ALUOp, funct, output alu_control, illegal, err_count);
`else
    modport master (output en, ALUOp, funct, input alu_control, illegal);
    modport slave  (input en, ALUOp, funct, output alu_control, illegal);
`endif
endinterface

// File: rtl/alu_control_unit.sv
// Registered ALU-control decoder: maps ALUOp/funct to a 4-bit ALU operation code.
// Optional macro ALUCTL_ERR_COUNT_EN adds a saturating illegal-decode counter (err_count).
module alu_control_unit #(
    parameter logic [3:0] RESET_CODE   = 4'b0000,
    parameter logic [3:0] ILLEGAL_CODE = 4'b1111
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_control_unit_if.slave  bus
);

    logic [3:0] next_code;
    logic       next_illegal;

    always_comb begin
        next_code    = ILLEGAL_CODE;
        next_illegal = 1'b1;
        case (bus.ALUOp)
            2'b00: begin
                next_code    = 4'b0111;
                next_illegal = 1'b0;
            end
            2'b01: begin
                next_code    = 4'b0110;
                next_illegal = 1'b0;
            end
            2'b10: begin
                next_illegal = 1'b0;
                case (bus.funct)
                    6'b100000: next_code = 4'b0010;
                    6'b100100: next_code = 4'b0110;
                    6'b100001: next_code = 4'b0011;
                    6'b100010: next_code = 4'b0100;
                    6'b100011: next_code = 4'b0101;
                    default: begin
                        next_code    = ILLEGAL_CODE;
                        next_illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                next_code    = ILLEGAL_CODE;
                next_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.alu_control <= RESET_CODE;
            bus.illegal     <= 1'b0;
        end else if (bus.en) begin
            bus.alu_control <= next_code;
            bus.illegal     <= next_illegal;
        end
    end

`ifdef ALUCTL_ERR_COUNT_EN
    // Counter sticks at 8'hFF until the next reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.err_count <= 8'h00;
        end else if (bus.en && next_illegal && (bus.err_count != 8'hFF)) begin
            bus.err_count <= bus.err_count + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed, table-driven bench for alu_control_unit, plus hand sequences for
// combinational-path isolation and (with ALUCTL_ERR_COUNT_EN) counter saturation.
module tb_alu_control_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    alu_control_unit_if bus ();

    alu_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] exp_code;
        logic       exp_ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] op, input logic [5:0] f);
        rst_n     = r;
        bus.en    = e;
        bus.ALUOp = op;
        bus.funct = f;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] op,
                                input logic [5:0] f, input logic [3:0] c, input logic il);
        vec_t v;
        v.rst_n = r; v.en = e; v.op = op; v.funct = f; v.exp_code = c; v.exp_ill = il;
        return v;
    endfunction

    initial begin
        // Expected values are the outputs seen after the edge that samples each row.
        vecs.push_back(mk(0, 1, 2'b10, 6'b100000, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 2'b10, 6'b100000, 4'b0000, 0));
        vecs.push_back(mk(1, 1, 2'b10, 6'b100000, 4'b0010, 0));
        vecs.push_back(mk(1, 1, 2'b10, 6'b100100, 4'b0110, 0));
        vecs.push_back(mk(1, 1, 2'b10, 6'b100001, 4'b0011, 0));
        vecs.push_back(mk(1, 1, 2'b10, 6'b100010, 4'b0100, 0));
        vecs.push_back(mk(1, 1, 2'b10, 6'b100011, 4'b0101, 0));
        vecs.push_back(mk(1, 1, 2'b00, 6'b000000, 4'b0111, 0));
        vecs.push_back(mk(1, 1, 2'b00, 6'b111111, 4'b0111, 0));
        vecs.push_back(mk(1, 1, 2'b01, 6'b101010, 4'b0110, 0));
        vecs.push_back(mk(1, 1, 2'b01, 6'b000000, 4'b0110, 0));
        vecs.push_back(mk(1, 1, 2'b10, 6'b111111, 4'b1111, 1));
        vecs.push_back(mk(1, 1, 2'b11, 6'b100000, 4'b1111, 1));
        vecs.push_back(mk(1, 1, 2'b10, 6'b100000, 4'b0010, 0));
        vecs.push_back(mk(1, 0, 2'b10, 6'b100010, 4'b0010, 0));
        vecs.push_back(mk(1, 0, 2'b10, 6'b100010, 4'b0010, 0));
        vecs.push_back(mk(1, 0, 2'b10, 6'b100010, 4'b0010, 0));
        vecs.push_back(mk(1, 1, 2'b10, 6'b100010, 4'b0100, 0));
        vecs.push_back(mk(1, 0, 2'b11, 6'b000000, 4'b0100, 0));
        vecs.push_back(mk(1, 1, 2'b10, 6'b000000, 4'b1111, 1));
        vecs.push_back(mk(1, 1, 2'b10, 6'b100101, 4'b1111, 1));
        vecs.push_back(mk(0, 1, 2'b10, 6'b100000, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 2'b10, 6'b100000, 4'b0000, 0));
        vecs.push_back(mk(1, 1, 2'b00, 6'b010101, 4'b0111, 0));
        vecs.push_back(mk(1, 1, 2'b10, 6'b100100, 4'b0110, 0));

        drive(0, 1, 2'b10, 6'b100000);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].op, vecs[i].funct);
            step();
            check($sformatf("vec%0d_code", i), {4'h0, bus.alu_control}, {4'h0, vecs[i].exp_code});
            check($sformatf("vec%0d_illegal", i), {7'h0, bus.illegal}, {7'h0, vecs[i].exp_ill});
`ifdef ALUCTL_ERR_COUNT_EN
            if (i == 1)
                check("err_count_in_reset", bus.err_count, 8'd0);
`endif
        end

        // Outputs must not follow inputs between edges.
        drive(1, 1, 2'b11, 6'b111111);
        #1;
        check("no_comb_path_code", {4'h0, bus.alu_control}, 8'h06);
        check("no_comb_path_illegal", {7'h0, bus.illegal}, 8'h00);
        step();
        check("after_edge_code", {4'h0, bus.alu_control}, 8'h0F);

`ifdef ALUCTL_ERR_COUNT_EN
        drive(0, 1, 2'b10, 6'b100000);
        step();
        check("err_count_reset", bus.err_count, 8'd0);
        drive(1, 1, 2'b11, 6'b000000);
        step();
        check("err_count_one", bus.err_count, 8'd1);
        for (int k = 1; k < 254; k++) step();
        check("err_count_254", bus.err_count, 8'd254);
        step();
        check("err_count_255", bus.err_count, 8'd255);
        for (int k = 255; k < 300; k++) step();
        check("err_count_saturate", bus.err_count, 8'd255);
        drive(0, 1, 2'b10, 6'b100000);
        step();
        check("err_count_reset2", bus.err_count, 8'd0);
        drive(1, 0, 2'b10, 6'b111111);
        for (int k = 0; k < 4; k++) step();
        check("err_count_hold_en0", bus.err_count, 8'd0);
        drive(1, 1, 2'b10, 6'b100000);
        step();
        check("err_count_legal", bus.err_count, 8'd0);
        drive(1, 1, 2'b10, 6'b111110);
        step();
        check("err_count_r_illegal", bus.err_count, 8'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_control_unit.md
Name: alu_control_unit

Overview:
- Registered ALU-control decoder for the 32-bit processor datapath.
- Maps the main-control `ALUOp` field and the R-type `funct` field to a 4-bit ALU operation code.
- Sits between the main control unit / instruction register and the ALU.
- Output is registered: one-cycle latency, stable for a full cycle.

Parameters:
- RESET_CODE, 4'b0000, value of `alu_control` after reset (NOP).
- ILLEGAL_CODE, 4'b1111, value of `alu_control` for undefined `ALUOp`/`funct` combinations.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  decode enable; when low, outputs hold.
- ALUOp  input  2  operation class from main control.
- funct  input  6  R-type function field, instr[5:0].
- alu_control  output  4  registered ALU operation code.
- illegal  output  1  registered flag: last decoded combination was undefined.
- err_count  output  8  saturating illegal-decode counter; present only with ALUCTL_ERR_COUNT_EN.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: sampled only on the rising edge of `clk` when `rst_n`=0.
- Reset:
  - `alu_control` <= RESET_CODE.
  - `illegal` <= 0.
  - `err_count` <= 0.
  - Reset has priority over `en`.
- Normal operation, `rst_n`=1 and `en`=1: decode `ALUOp`/`funct` combinationally and register the result.
  - New code visible on `alu_control` one cycle after sampling.
- `rst_n`=1 and `en`=0: `alu_control` and `illegal` hold their previous values; `err_count` unchanged.
- Decode table (next-state values):
  - `ALUOp`=00 (MOVI): `alu_control`=0111 (pass immediate). `funct` ignored. `illegal`=0.
  - `ALUOp`=01 (compare/branch): `alu_control`=0110 (SUB). `funct` ignored. `illegal`=0.
  - `ALUOp`=10 (R-type), decode on `funct`:
    - 100000 ADD -> 0010
    - 100100 SUB -> 0110
    - 100001 MULT -> 0011
    - 100010 DIV -> 0100
    - 100011 MOV -> 0101
    - All listed codes: `illegal`=0.
    - Any other `funct` -> ILLEGAL_CODE, `illegal`=1.
  - `ALUOp`=11 (reserved): ILLEGAL_CODE, `illegal`=1, regardless of `funct`.
- No X-propagation beyond the table: every input combination maps to a defined code.
- Outputs change only at clock edges. No combinational path from inputs to outputs.
- Reset asserted mid-stream: the next edge forces the reset values; the pending decode is discarded.
- After `rst_n` deasserts, the first enabled edge loads a decoded value.

Optional Feature:
- Macro: ALUCTL_ERR_COUNT_EN.
- Defined:
  - `err_count` port exists.
  - Increments by 1 on every enabled, non-reset edge whose decode sets `illegal`=1.
  - Saturates at 8'hFF; no wrap.
  - Cleared only by reset.
- Not defined:
  - `err_count` port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: hold `rst_n`=0 for 2 edges with `ALUOp`=10, `funct`=100000 -> `alu_control`=0000, `illegal`=0 (and `err_count`=0). Release; the next edge gives 0010.
- R-type sweep, `en`=1, `ALUOp`=10: apply `funct` 100000, 100100, 100001, 100010, 100011 on consecutive cycles -> one cycle later each: 0010, 0110, 0011, 0100, 0101, with `illegal`=0.
- Don't-care `funct`:
  - `ALUOp`=00 with `funct`=000000, then `funct`=111111 -> 0111 both times.
  - `ALUOp`=01 with any `funct` -> 0110.
- Illegal decodes: `ALUOp`=10, `funct`=111111 -> 1111 and `illegal`=1. `ALUOp`=11, `funct`=100000 -> 1111 and `illegal`=1. The following legal ADD clears `illegal` to 0.
- Enable hold: decode ADD (0010), drop `en`, apply `funct`=100010 for 3 cycles -> `alu_control` stays 0010. Raise `en` -> 0100 on the next edge.
- ALUCTL_ERR_COUNT_EN:
  - 300 consecutive illegal decodes -> `err_count` saturates at 255.
  - Illegal inputs held while `en`=0 -> no increment.
  - Reset -> 0.
